flash_read_arbiter: RTL and testbench
=====================================

FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 Parameter: ADDR_W, 23, flash word address width.
REQ-002 Parameter: DATA_W, 32, flash read data width.
REQ-003 Parameter: TIMEOUT_CYCLES, 4096, WAIT_DATA cycle limit; used only under FLASH_ARB_TIMEOUT_EN.
REQ-004 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-005 Ports SHALL be:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  async active-low reset
- rq_read[1:0]  in  2  per-requester read request
- rq_address[1:0]  in  2xADDR_W  per-requester word address
- rq_waitrequest[1:0]  out  2  per-requester stall, Avalon-MM semantics
- rq_readdata  out  DATA_W  returned data, shared by both requesters
- rq_readdatavalid[1:0]  out  2  per-requester data-valid pulse
- flash_mem_read  out  1  flash read command
- flash_mem_address  out  ADDR_W  flash address
- flash_mem_waitrequest  in  1  flash stall
- flash_mem_readdata  in  DATA_W  flash data
- flash_mem_readdatavalid  in  1  flash data valid
- timeout_pulse  out  1  one-cycle flag for an abandoned read

Function
REQ-006 The block SHALL share one Avalon-MM read port between two requesters, with at most one outstanding read.
REQ-007 The state machine SHALL have three states: IDLE, ISSUE and WAIT_DATA.
REQ-008 IDLE: if any rq_read is high, the block SHALL grant one requester, latch its address, and go to ISSUE on the next edge.
REQ-009 Grant order SHALL be round-robin on last_grant; with both requesting, the requester other than last_grant wins; last_grant resets to 1, so rq0 wins first.
REQ-010 ISSUE: flash_mem_read SHALL be 1 and flash_mem_address SHALL be the latched address; when flash_mem_waitrequest=0, the block SHALL go to WAIT_DATA.
REQ-011 rq_waitrequest[n] SHALL be 0 only in the ISSUE cycle in which grant=n and flash_mem_waitrequest=0, and 1 otherwise, including in IDLE.
REQ-012 WAIT_DATA: flash_mem_read SHALL be 0; on flash_mem_readdatavalid, the block SHALL register the data into rq_readdata, pulse rq_readdatavalid[grant] on the following cycle, update last_grant, and go to IDLE.
REQ-013 Latency: flash_mem_read SHALL assert 1 cycle after rq_read is sampled in IDLE; rq_readdatavalid SHALL assert 1 cycle after flash_mem_readdatavalid.
REQ-014 Each transaction SHALL take one IDLE cycle minimum; there is no back-to-back issue.
REQ-015 flash_mem_readdatavalid in IDLE or ISSUE SHALL be ignored.
REQ-016 A requester dropping rq_read after grant SHALL NOT abort the read; the data SHALL still be delivered to that requester.
REQ-017 rq_readdatavalid SHALL be one-hot or zero, never 2'b11.

Reset
REQ-018 On rst_n=0, asynchronously: state=IDLE, last_grant=1, flash_mem_read=0, flash_mem_address=0, rq_readdatavalid=0, rq_readdata=0, timeout_pulse=0, timeout counter=0.
REQ-019 Reset mid-read SHALL discard the outstanding read; a late flash_mem_readdatavalid after release SHALL be ignored per REQ-015.

Configuration
REQ-020 Macro FLASH_ARB_TIMEOUT_EN defined: the block SHALL count cycles in WAIT_DATA; at TIMEOUT_CYCLES without valid data it SHALL return rq_readdata=0, pulse rq_readdatavalid[grant] and timeout_pulse, and go to IDLE.
REQ-021 Macro FLASH_ARB_TIMEOUT_EN undefined: WAIT_DATA SHALL wait indefinitely, timeout_pulse SHALL be tied to 0, and no counter SHALL be instantiated.

Structure
REQ-022 Package flash_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT_DATA), the default ADDR_W and DATA_W, and the default TIMEOUT_CYCLES.
REQ-023 Sub-module rr_arbiter2 (2-way round-robin grant from req and last_grant) SHALL be the only child; the FSM and datapath SHALL stay in the top.

Verification
REQ-024 rq0 reads addr 0x000010, flash waitrequest=1 for 3 cycles, data 0xDEADBEEF 5 cycles later -> rq_waitrequest[0] falls once, rq_readdatavalid[0] pulses once, rq_readdata=0xDEADBEEF, rq1 untouched.
REQ-025 Both requesters hold rq_read for 4 transactions -> grants rq0,rq1,rq0,rq1; flash_mem_address alternates between the two addresses.
REQ-026 Only rq1 requests repeatedly -> rq1 is granted every transaction with no starvation gap beyond REQ-014.
REQ-027 rst_n asserted in WAIT_DATA, valid arrives 2 cycles after release -> no rq_readdatavalid, state IDLE.
REQ-028 With FLASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, flash never returns data -> at cycle 16 of WAIT_DATA, timeout_pulse=1, rq_readdatavalid[grant]=1, rq_readdata=0; without the macro the block stays in WAIT_DATA.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared types and default sizing for the two-requester flash read arbiter.
`timescale 1ns/1ps
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_e;

  localparam int FLASH_ADDR_W_DEF         = 23;
  localparam int FLASH_DATA_W_DEF         = 32;
  localparam int FLASH_TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester-side and flash-side Avalon-MM read signals of the arbiter.
`timescale 1ns/1ps
interface flash_read_arbiter_if
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W_DEF,
  parameter int DATA_W = FLASH_DATA_W_DEF
) ();

  logic [1:0]             rq_read;
  logic [1:0][ADDR_W-1:0] rq_address;
  logic [1:0]             rq_waitrequest;
  logic [DATA_W-1:0]      rq_readdata;
  logic [1:0]             rq_readdatavalid;

  logic                   flash_mem_read;
  logic [ADDR_W-1:0]      flash_mem_address;
  logic                   flash_mem_waitrequest;
  logic [DATA_W-1:0]      flash_mem_readdata;
  logic                   flash_mem_readdatavalid;

  // Arbiter view
  modport slave (
    input  rq_read, rq_address, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
    output rq_waitrequest, rq_readdata, rq_readdatavalid, flash_mem_read, flash_mem_address
  );

  // Environment view: requesters plus flash device
  modport master (
    output rq_read, rq_address, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
    input  rq_waitrequest, rq_readdata, rq_readdatavalid, flash_mem_read, flash_mem_address
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that was not served last wins.
`timescale 1ns/1ps
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read port between two requesters, one read outstanding.
// Optional WAIT_DATA timeout is built only when FLASH_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W         = FLASH_ADDR_W_DEF,
  parameter int DATA_W         = FLASH_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = FLASH_TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flash_read_arbiter_if.slave  bus,
  output logic                 timeout_pulse
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e state;
  logic       grant;
  logic       last_grant;
  logic       arb_grant;
  logic       arb_valid;

  rr_arbiter2 u_rr_arbiter2 (
    .req        (bus.rq_read),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // The requester only sees its stall drop in the exact cycle the flash accepts the command.
  always_comb begin
    bus.rq_waitrequest = 2'b11;
    if ((state == ISSUE) && !bus.flash_mem_waitrequest) begin
      bus.rq_waitrequest[grant] = 1'b0;
    end
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
`else
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      grant                 <= 1'b0;
      last_grant            <= 1'b1;
      bus.flash_mem_read    <= 1'b0;
      bus.flash_mem_address <= {ADDR_W{1'b0}};
      bus.rq_readdatavalid  <= 2'b00;
      bus.rq_readdata       <= {DATA_W{1'b0}};
`ifdef FLASH_ARB_TIMEOUT_EN
      timeout_pulse         <= 1'b0;
      to_cnt                <= '0;
`endif
    end else begin
      bus.rq_readdatavalid <= 2'b00;
`ifdef FLASH_ARB_TIMEOUT_EN
      timeout_pulse        <= 1'b0;
      to_cnt               <= '0;
`endif
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant                 <= arb_grant;
            bus.flash_mem_address <= bus.rq_address[arb_grant];
            bus.flash_mem_read    <= 1'b1;
            state                 <= ISSUE;
          end
        end

        ISSUE: begin
          if (!bus.flash_mem_waitrequest) begin
            bus.flash_mem_read <= 1'b0;
            state              <= WAIT_DATA;
          end
        end

        // Completion goes to the granted requester even if it has since dropped rq_read.
        WAIT_DATA: begin
          if (bus.flash_mem_readdatavalid) begin
            bus.rq_readdata             <= bus.flash_mem_readdata;
            bus.rq_readdatavalid[grant] <= 1'b1;
            last_grant                  <= grant;
            state                       <= IDLE;
          end
`ifdef FLASH_ARB_TIMEOUT_EN
          else if (to_cnt == CNT_LAST) begin
            bus.rq_readdata             <= {DATA_W{1'b0}};
            bus.rq_readdatavalid[grant] <= 1'b1;
            timeout_pulse               <= 1'b1;
            last_grant                  <= grant;
            state                       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: a flash model serves reads and expected returns are checked on rq_readdatavalid.
`timescale 1ns/1ps
module tb_flash_read_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic timeout_pulse;

  flash_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  flash_read_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .timeout_pulse (timeout_pulse)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   wlo[2]   = '{0, 0};
  int   rdvc[2]  = '{0, 0};
  int   last_issue = 0;
  int   gap = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400_000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled mid-low-phase, after the bench has driven inputs on the falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    #5;
    for (int n = 0; n < 2; n++) if (!bus.rq_waitrequest[n]) wlo[n]++;
    if (bus.rq_readdatavalid != 2'b00) begin
      if (bus.rq_readdatavalid[0]) rdvc[0]++;
      if (bus.rq_readdatavalid[1]) rdvc[1]++;
      if (sb.size() == 0) begin
        chk("rdv_unexpected", bus.rq_readdatavalid, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("rdv_onehot", bus.rq_readdatavalid, e.id ? 2'b10 : 2'b01);
        chk("rdata", bus.rq_readdata, e.data);
        chk("rdv_latency", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Flash device model for one read: stall wr_cyc cycles, return data lat cycles after accept.
  task automatic serve(input int wr_cyc, input int lat, input logic [DATA_W-1:0] data,
                       input logic [ADDR_W-1:0] addr, input logic id, input bit drop);
    int t = 0;
    while (bus.flash_mem_read !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("issue_seen", bus.flash_mem_read, 1'b1);
    if (bus.flash_mem_read !== 1'b1) return;
    chk("flash_addr", bus.flash_mem_address, addr);
    gap = cyc - last_issue;
    last_issue = cyc;
    repeat (wr_cyc) @(negedge clk);
    bus.flash_mem_waitrequest = 1'b0;
    @(negedge clk);
    bus.flash_mem_waitrequest = 1'b1;
    if (drop) bus.rq_read[id] = 1'b0;
    chk("read_deasserted", bus.flash_mem_read, 1'b0);
    repeat (lat - 1) @(negedge clk);
    bus.flash_mem_readdata      = data;
    bus.flash_mem_readdatavalid = 1'b1;
    sb.push_back('{id: id, data: data, cyc: cyc + 1});
    @(negedge clk);
    bus.flash_mem_readdatavalid = 1'b0;
  endtask

  initial begin
    int w0, w1, r0, r1;
    logic [ADDR_W-1:0] a0, a1;

    rst_n = 1'b0;
    bus.rq_read = 2'b00;
    bus.rq_address = '0;
    bus.flash_mem_waitrequest = 1'b1;
    bus.flash_mem_readdata = '0;
    bus.flash_mem_readdatavalid = 1'b0;
    do_reset();

    // Reset state
    chk("rst_read", bus.flash_mem_read, 1'b0);
    chk("rst_addr", bus.flash_mem_address, '0);
    chk("rst_rdv", bus.rq_readdatavalid, 2'b00);
    chk("rst_rdata", bus.rq_readdata, '0);
    chk("rst_wreq", bus.rq_waitrequest, 2'b11);
    chk("rst_timeout", timeout_pulse, 1'b0);

    // Single read from rq0 with flash stall and delayed data
    w0 = wlo[0]; w1 = wlo[1]; r0 = rdvc[0]; r1 = rdvc[1];
    bus.rq_address[0] = 23'h000010;
    bus.rq_read[0] = 1'b1;
    @(negedge clk);
    chk("issue_lat", bus.flash_mem_read, 1'b1);
    serve(3, 5, 32'hDEADBEEF, 23'h000010, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t1_wreq0_falls", wlo[0] - w0, 1);
    chk("t1_wreq1_quiet", wlo[1] - w1, 0);
    chk("t1_rdv0_once", rdvc[0] - r0, 1);
    chk("t1_rdv1_quiet", rdvc[1] - r1, 0);
    chk("t1_rdata_held", bus.rq_readdata, 32'hDEADBEEF);

    // Both requesters held: grants alternate starting with rq0
    do_reset();
    a0 = 23'h0000AA;
    a1 = 23'h155555;
    bus.rq_address[0] = a0;
    bus.rq_address[1] = a1;
    bus.rq_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(i % 2, 1 + i, 32'h1000_0000 + i, (i % 2) ? a1 : a0, 1'(i % 2), 1'b0);
    end
    bus.rq_read = 2'b00;
    repeat (3) @(negedge clk);

    // Only rq1 requests: served every transaction at the minimum period
    bus.rq_address[1] = 23'h00ABCD;
    bus.rq_read[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serve(0, 1, 32'h2000_0000 + i, 23'h00ABCD, 1'b1, i == 2);
      if (i > 0) chk("rq1_gap", gap, 3);
    end
    repeat (3) @(negedge clk);

    // rq1 drops rq_read right after grant; data still delivered to rq1
    r1 = rdvc[1];
    bus.rq_address[1] = 23'h000321;
    bus.rq_read[1] = 1'b1;
    @(negedge clk);
    bus.rq_read[1] = 1'b0;
    serve(2, 2, 32'hCAFE_0001, 23'h000321, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("drop_still_delivered", rdvc[1] - r1, 1);

    // Stray flash valid in IDLE and in ISSUE is ignored
    r0 = rdvc[0]; r1 = rdvc[1];
    bus.flash_mem_readdata = 32'hBAD0_0001;
    bus.flash_mem_readdatavalid = 1'b1;
    @(negedge clk);
    bus.flash_mem_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_valid_ignored", (rdvc[0] - r0) + (rdvc[1] - r1), 0);
    bus.rq_address[0] = 23'h000003;
    bus.rq_read[0] = 1'b1;
    @(negedge clk);
    chk("issue_lat2", bus.flash_mem_read, 1'b1);
    bus.flash_mem_readdata = 32'hBAD0_0002;
    bus.flash_mem_readdatavalid = 1'b1;
    @(negedge clk);
    bus.flash_mem_readdatavalid = 1'b0;
    serve(1, 3, 32'h0BAD_F00D, 23'h000003, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("issue_valid_ignored", rdvc[0] - r0, 1);

    // Reset while waiting for data; late valid after release is dropped
    r0 = rdvc[0]; r1 = rdvc[1];
    bus.rq_address[0] = 23'h000007;
    bus.rq_read[0] = 1'b1;
    @(negedge clk);
    bus.flash_mem_waitrequest = 1'b0;
    @(negedge clk);
    bus.flash_mem_waitrequest = 1'b1;
    bus.rq_read[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #5;
    chk("async_rst_addr", bus.flash_mem_address, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.flash_mem_readdata = 32'h5A5A_5A5A;
    bus.flash_mem_readdatavalid = 1'b1;
    @(negedge clk);
    bus.flash_mem_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_valid_ignored", (rdvc[0] - r0) + (rdvc[1] - r1), 0);
    bus.rq_read[0] = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", bus.flash_mem_read, 1'b1);
    serve(0, 2, 32'h1234_5678, 23'h000007, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Flash never returns data
    r1 = rdvc[1];
    bus.rq_address[1] = 23'h0000F0;
    bus.rq_read[1] = 1'b1;
    @(negedge clk);
    chk("issue_lat3", bus.flash_mem_read, 1'b1);
    bus.flash_mem_waitrequest = 1'b0;
    @(negedge clk);
    bus.flash_mem_waitrequest = 1'b1;
    bus.rq_read[1] = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("timeout_early", timeout_pulse, 1'b0);
    sb.push_back('{id: 1'b1, data: '0, cyc: cyc + 1});
    @(negedge clk);
    chk("timeout_pulse", timeout_pulse, 1'b1);
    @(negedge clk);
    chk("timeout_one_cycle", timeout_pulse, 1'b0);
    chk("timeout_rdv1", rdvc[1] - r1, 1);
`else
    repeat (40) @(negedge clk);
    chk("no_timeout_rdv", rdvc[1] - r1, 0);
    chk("no_timeout_pulse", timeout_pulse, 1'b0);
    chk("no_timeout_read", bus.flash_mem_read, 1'b0);
    bus.flash_mem_readdata = 32'hFEED_0042;
    bus.flash_mem_readdatavalid = 1'b1;
    sb.push_back('{id: 1'b1, data: 32'hFEED_0042, cyc: cyc + 1});
    @(negedge clk);
    bus.flash_mem_readdatavalid = 1'b0;
    @(negedge clk);
    chk("still_waiting_delivers", rdvc[1] - r1, 1);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
